// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM encoding is fixed by localparams so state values stay stable across builds.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Bit-counter width: enough to hold 0..w-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Purely combinational; the serial datapath reuses this single cell every cycle.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH) with final borrow.
// One bit per clock, LSB first, using a single full_subtractor cell and a
// borrow flip-flop. Optional macro SUB_OVF_EN adds a signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_count;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_load;
  logic             w_finish;

  full_subtractor u_fs (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_bin (r_borrow),
    .o_d   (w_d),
    .o_bout(w_bout)
  );

  // New result bit enters at the MSB; after the last shift this is the full difference.
  assign w_res_next = {w_d, r_res_sr};
  // A start is only honoured when no operation is in flight.
  assign w_load     = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_finish   = (r_state == SHIFT) && (r_count == LAST);

  // Control FSM and datapath: load operands, shift one bit per cycle, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a_sr     <= {WIDTH{1'b0}};
      r_b_sr     <= {WIDTH{1'b0}};
      r_res_sr   <= {(WIDTH-1){1'b0}};
      r_borrow   <= 1'b0;
      r_count    <= {CW{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (w_load) begin
            r_state  <= SHIFT;
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_count  <= {CW{1'b0}};
            busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        SHIFT: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_res_sr <= w_res_next[WIDTH-1:1];
          r_borrow <= w_bout;
          r_count  <= r_count + CW'(1);
          if (w_finish) begin
            r_state    <= DONE;
            diff       <= w_res_next;
            borrow_out <= w_bout;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            r_state <= SHIFT;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUB_OVF_EN
  logic r_a_sign;
  logic r_b_sign;

  // Capture operand signs at load and evaluate signed overflow when the result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_sign <= a[WIDTH-1];
        r_b_sign <= b[WIDTH-1];
      end
      if (w_finish) begin
        ovf <= (r_a_sign != r_b_sign) && (w_res_next[WIDTH-1] != r_a_sign);
      end
    end
  end
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Covers SUB_OVF_EN checks when that macro is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  bit seen;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    a = aa;
    b = bb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles until done is seen, bounded.
  task automatic wait_done(output int n, output bit got);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) n++;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] aa,
                               input logic [W-1:0] bb, input logic [W-1:0] ed,
                               input logic eb);
    start_op(aa, bb);
    wait_done(cyc, seen);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(cyc), 32'd8);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    @(negedge clk);
    check({tag, "_done_pulse_1cyc"}, 32'(done), 32'd0);
    check({tag, "_diff_held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // T1: basic subtraction with latency check
    start_op(8'd200, 8'd55);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_diff_old_kept", 32'(diff), 32'd0);
    wait_done(cyc, seen);
    check("t1_done_seen", 32'(seen), 32'd1);
    check("t1_busy_cycles", 32'(cyc), 32'd8);
    check("t1_diff", 32'(diff), 32'd145);
    check("t1_borrow", 32'(borrow_out), 32'd0);
    check("t1_busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 32'd0);

    // T2: borrow case, zero case, extremes
    run_and_check("t2_5m10", 8'd5, 8'd10, 8'd251, 1'b1);
    run_and_check("t2_0m0", 8'd0, 8'd0, 8'd0, 1'b0);
    run_and_check("t2_255m0", 8'd255, 8'd0, 8'd255, 1'b0);
    run_and_check("t2_0m255", 8'd0, 8'd255, 8'd1, 1'b1);
    run_and_check("t2_170m85", 8'd170, 8'd85, 8'd85, 1'b0);

    // T3: start during SHIFT is ignored
    start_op(8'd200, 8'd55);
    @(negedge clk);
    @(negedge clk);
    a = 8'd1;
    b = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, seen);
    check("t3_done_seen", 32'(seen), 32'd1);
    check("t3_remaining_busy", 32'(cyc), 32'd5);
    check("t3_diff", 32'(diff), 32'd145);
    check("t3_borrow", 32'(borrow_out), 32'd0);

    // T4: back-to-back start in the DONE cycle
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_done_dropped", 32'(done), 32'd0);
    check("t4_busy_restart", 32'(busy), 32'd1);
    check("t4_diff_held_during_op", 32'(diff), 32'd145);
    wait_done(cyc, seen);
    check("t4_done_seen", 32'(seen), 32'd1);
    check("t4_busy_cycles", 32'(cyc), 32'd8);
    check("t4_diff", 32'(diff), 32'd0);
    check("t4_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);

    // T5: asynchronous reset mid-operation
    start_op(8'd5, 8'd10);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_done", 32'(done), 32'd0);
    check("t5_async_diff", 32'(diff), 32'd0);
    check("t5_async_borrow", 32'(borrow_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("t5_no_activity_after_abort", 32'(seen), 32'd0);
    run_and_check("t5_after", 8'd100, 8'd30, 8'd70, 1'b0);

`ifdef SUB_OVF_EN
    // T6: signed overflow flag
    run_and_check("t6_80m01", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("t6_ovf_set", 32'(ovf), 32'd1);
    run_and_check("t6_10m01", 8'h10, 8'h01, 8'h0F, 1'b0);
    check("t6_ovf_clr", 32'(ovf), 32'd0);
    run_and_check("t6_7Fm80", 8'h7F, 8'h80, 8'hFF, 1'b1);
    check("t6_ovf_pos_neg", 32'(ovf), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
